// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter with bounded grant tenure and a registered output mux for three requesters
module mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic [WIDTH-1:0] ip3,
  output logic [2:0]       gnt,
  output logic [WIDTH-1:0] mux_op,
  output logic             op_valid
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [1:0] last_owner, owner_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [2:0] gnt_nxt;
  logic [WIDTH-1:0] mux_nxt;
  logic any, keep;
  function automatic logic [1:0] arb(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] a, b;
    a = (p == 2'd2) ? 2'd0 : p + 2'd1;
    b = (a == 2'd2) ? 2'd0 : a + 2'd1;
    return r[a] ? a : r[b] ? b : p;
  endfunction
  always_comb begin
    any       = |req;
    keep      = (state == GRANT) && req[last_owner] && (hold_cnt != HMAX);
    owner_nxt = keep ? last_owner : arb(last_owner, req);
    state_nxt = any ? GRANT : IDLE;
    hold_nxt  = !any ? '0 : keep ? hold_cnt + HW'(1) : HW'(1);
    gnt_nxt   = any ? 3'(1) << owner_nxt : 3'b000;
    mux_nxt   = !any ? mux_op : (owner_nxt == 2'd0) ? ip1 : (owner_nxt == 2'd1) ? ip2 : ip3;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
      gnt        <= '0;
      mux_op     <= '0;
      op_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= any ? owner_nxt : last_owner;
      hold_cnt   <= hold_nxt;
      gnt        <= gnt_nxt;
      mux_op     <= mux_nxt;
      op_valid   <= any;
    end
  end
  a_req_known: assert property (@(posedge clock) disable iff (!reset_n) !$isunknown(req));
  a_onehot:    assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt));
  a_valid:     assert property (@(posedge clock) disable iff (!reset_n) op_valid == |gnt);
  a_mux0:      assert property (@(posedge clock) disable iff (!reset_n) gnt[0] |-> mux_op == $past(ip1));
  a_mux1:      assert property (@(posedge clock) disable iff (!reset_n) gnt[1] |-> mux_op == $past(ip2));
  a_mux2:      assert property (@(posedge clock) disable iff (!reset_n) gnt[2] |-> mux_op == $past(ip3));
  a_hold_max:  assert property (@(posedge clock) disable iff (!reset_n) hold_cnt <= HMAX);
  // Tenure expired with a competitor waiting: ownership must move on the next edge.
  a_rotate:    assert property (@(posedge clock) disable iff (!reset_n)
                 (gnt != 3'b000 && hold_cnt == HMAX && (req & ~gnt) != 3'b000) |=> gnt != $past(gnt));
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed vector table plus hand sequences for reset, rotation and MAX_HOLD=1.
module tb_mux_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [3:0] ip1 = 4'h1, ip2 = 4'h2, ip3 = 4'h3;
  logic [2:0] gnt4, gnt1;
  logic [3:0] mux4, mux1;
  logic val4, val1;
  int applied = 0;
  int miscompares = 0;
  typedef struct {
    logic [2:0] req;
    logic [3:0] d1, d2, d3;
    logic [2:0] eg;
    logic [3:0] em;
    logic       ev;
  } vec_t;
  vec_t v[$];
  mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .req(req), .ip1(ip1), .ip2(ip2), .ip3(ip3),
    .gnt(gnt4), .mux_op(mux4), .op_valid(val4));
  mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .ip1(ip1), .ip2(ip2), .ip3(ip3),
    .gnt(gnt1), .mux_op(mux1), .op_valid(val1));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [2:0] r, input logic [3:0] a, b, c,
                              input logic [2:0] g, input logic [3:0] m, input logic e);
    vec_t t;
    t.req = r; t.d1 = a; t.d2 = b; t.d3 = c; t.eg = g; t.em = m; t.ev = e;
    return t;
  endfunction
  initial begin
    // all three requesting: 4 cycles each, rotating 0 -> 1 -> 2 -> 0
    for (int i = 0; i < 4; i++) v.push_back(mk(3'b111, 4'h1, 4'h2, 4'h3, 3'b001, 4'h1, 1'b1));
    for (int i = 0; i < 4; i++) v.push_back(mk(3'b111, 4'h1, 4'h2, 4'h3, 3'b010, 4'h2, 1'b1));
    for (int i = 0; i < 4; i++) v.push_back(mk(3'b111, 4'h1, 4'h2, 4'h3, 3'b100, 4'h3, 1'b1));
    v.push_back(mk(3'b111, 4'h1, 4'h2, 4'h3, 3'b001, 4'h1, 1'b1));
    // owner 0 drops while requester 2 waits: switch with no bubble
    v.push_back(mk(3'b100, 4'h1, 4'h2, 4'h3, 3'b100, 4'h3, 1'b1));
    v.push_back(mk(3'b100, 4'h1, 4'h2, 4'h5, 3'b100, 4'h5, 1'b1));
    // everyone drops: idle, mux_op holds last data
    v.push_back(mk(3'b000, 4'h1, 4'h2, 4'h9, 3'b000, 4'h5, 1'b0));
    v.push_back(mk(3'b000, 4'h1, 4'h2, 4'h9, 3'b000, 4'h5, 1'b0));
    v.push_back(mk(3'b001, 4'h1, 4'h2, 4'h3, 3'b001, 4'h1, 1'b1));
    // lone requester 1 keeps the grant across hold expiry
    for (int i = 0; i < 10; i++) v.push_back(mk(3'b010, 4'h1, 4'hA, 4'h3, 3'b010, 4'hA, 1'b1));
    v.push_back(mk(3'b010, 4'h1, 4'h7, 4'h3, 3'b010, 4'h7, 1'b1));
    req = 3'b111;
    #12;
    chk("reset_gnt", 32'(gnt4), 32'h0);
    chk("reset_mux", 32'(mux4), 32'h0);
    chk("reset_valid", 32'(val4), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      req = v[i].req; ip1 = v[i].d1; ip2 = v[i].d2; ip3 = v[i].d3;
      @(posedge clock); #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt4), 32'(v[i].eg));
      chk($sformatf("vec%0d_mux", i), 32'(mux4), 32'(v[i].em));
      chk($sformatf("vec%0d_valid", i), 32'(val4), 32'(v[i].ev));
    end
    // asynchronous reset mid-grant takes effect between edges
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt4), 32'h0);
    chk("async_rst_mux", 32'(mux4), 32'h0);
    chk("async_rst_valid", 32'(val4), 32'h0);
    req = 3'b110;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_gnt", 32'(gnt4), 32'h2);
    chk("post_rst_mux", 32'(mux4), 32'h7);
    // MAX_HOLD=1 instance alternates every cycle between requesters 0 and 2
    @(negedge clock);
    reset_n = 1'b0;
    req = 3'b101; ip1 = 4'hC; ip2 = 4'h2; ip3 = 4'hD;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk($sformatf("mh1_%0d_gnt", i), 32'(gnt1), (i % 2 == 0) ? 32'h1 : 32'h4);
      chk($sformatf("mh1_%0d_mux", i), 32'(mux1), (i % 2 == 0) ? 32'hC : 32'hD);
      chk($sformatf("mh1_%0d_valid", i), 32'(val1), 32'h1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
